pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage. It owns the architectural PC register and chooses each cycle between sequential advance, hold, branch/JAL redirect, JALR redirect and trap entry. It issues fetch requests to instruction memory and generates a one-cycle flush after every redirect. The PC is a word index (instruction number, byte address >> 2), the same unit as the branch-target adder output.

---
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: owns the architectural PC
// (word index), selects sequential / hold / branch / JALR / trap targets,
// issues fetch requests and produces a one-cycle flush after each redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_target,
  input  logic        trap_req,
  input  logic [31:0] ex_pc,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic        flush,
  output logic [31:0] epc,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] epc_n;
  logic        flush_n;
  logic        misalign_n;
  logic        jalr_mis;

  // A JALR whose byte target is not word aligned is handled as a trap.
  assign jalr_mis = jalr_valid && (jalr_target[1:0] != 2'b00);

  // Fetch request depends combinationally only on stall.
  assign imem_req = (state == RUN) && !stall;

  // Next-state, next-PC and pulse selection by fixed event priority.
  always_comb begin
    state_n    = state;
    pc_n       = pc_out;
    epc_n      = epc;
    flush_n    = 1'b0;
    misalign_n = 1'b0;
    unique case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN, FLUSH: begin
        state_n = RUN;
        // Trap-class events are honoured in both RUN and FLUSH; the other
        // redirects and sequential advance only in RUN, since during FLUSH
        // those inputs come from killed instructions.
        if (trap_req || jalr_mis) begin
          pc_n       = TRAP_PC;
          epc_n      = ex_pc;
          misalign_n = jalr_mis;
          flush_n    = 1'b1;
          state_n    = FLUSH;
        end else if (state == RUN) begin
          if (jalr_valid) begin
            pc_n    = {2'b00, jalr_target[31:2]};
            flush_n = 1'b1;
            state_n = FLUSH;
          end else if (br_taken) begin
            pc_n    = br_target;
            flush_n = 1'b1;
            state_n = FLUSH;
          end else if (!stall && imem_ready) begin
            pc_n = pc_out + 32'd1;
          end
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  // Architectural PC, trap PC, pulses and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_out   <= RESET_PC;
      epc      <= '0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc_out   <= pc_n;
      epc      <= epc_n;
      flush    <= flush_n;
      misalign <= misalign_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jalr_valid, trap_req, imem_ready;
  logic [31:0] br_target, jalr_target, ex_pc;
  logic [31:0] pc_out, epc;
  logic        imem_req, flush, misalign;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: booting = first edge after reset release is spent
  // booting; killed = previous edge was a redirect (bubble cycle).
  logic [31:0] m_pc, m_epc;
  logic        m_flush, m_mis, m_booting, m_killed;

  pc_sequencer #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .trap_req(trap_req), .ex_pc(ex_pc), .imem_ready(imem_ready),
    .pc_out(pc_out), .imem_req(imem_req), .flush(flush), .epc(epc),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
    chk({tag, ".epc"}, epc, m_epc);
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
  endtask

  // Called at posedge+1: drives one cycle of inputs, checks imem_req,
  // advances the model, clocks, then checks registered outputs.
  task automatic cyc(input string tag, input logic s, input logic bt, input logic [31:0] btg,
                     input logic jv, input logic [31:0] jt, input logic tr,
                     input logic [31:0] ep, input logic rdy);
    logic mis, redir;
    stall = s; br_taken = bt; br_target = btg; jalr_valid = jv;
    jalr_target = jt; trap_req = tr; ex_pc = ep; imem_ready = rdy;
    #1;
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, (!m_booting && !m_killed && !s)});
    mis   = jv && (jt % 4 != 0);
    redir = 1'b0;
    m_mis = 1'b0;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (tr || mis) begin
      m_pc = TRP_PC; m_epc = ep; m_mis = mis; redir = 1'b1;
    end else if (!m_killed) begin
      if (jv) begin
        m_pc = jt / 4; redir = 1'b1;
      end else if (bt) begin
        m_pc = btg; redir = 1'b1;
      end else if (!s && rdy) begin
        m_pc = m_pc + 32'd1;
      end
    end
    m_flush  = redir;
    m_killed = redir;
    @(posedge clk); #1;
    chk_regs(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    cyc(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_pc = RST_PC; m_epc = '0; m_flush = 1'b0; m_mis = 1'b0;
    m_booting = 1'b1; m_killed = 1'b0;
    chk_regs("reset");
    chk("reset.req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; br_taken = 0; jalr_valid = 0; trap_req = 0; imem_ready = 0;
    br_target = '0; jalr_target = '0; ex_pc = '0;
    @(posedge clk); #1;
    do_reset();

    // Boot then four sequential fetches: 0,0,1,2,3,4.
    idle("boot", 1'b1);
    for (int i = 0; i < 4; i++) idle("seq", 1'b1);

    // Hold at 10: two not-ready cycles then a stall with ready.
    cyc("br10", 0, 1, 32'd10, 0, '0, 0, '0, 1);
    idle("fl10", 1'b1);
    idle("nrdy", 1'b0);
    idle("nrdy", 1'b0);
    cyc("stall", 1, 0, '0, 0, '0, 0, '0, 1);
    idle("adv11", 1'b1);

    // Branch with stall at 20.
    cyc("br20", 0, 1, 32'd20, 0, '0, 0, '0, 1);
    idle("fl20", 1'b1);
    cyc("br7", 1, 1, 32'd7, 0, '0, 0, '0, 1);
    idle("fl7", 1'b1);
    idle("adv8", 1'b1);

    // Misaligned then aligned JALR.
    cyc("jmis", 0, 0, '0, 1, 32'h0000_0102, 0, 32'd33, 1);
    idle("fljm", 1'b1);
    cyc("jal", 0, 0, '0, 1, 32'h0000_0100, 0, 32'd34, 1);
    idle("flj", 1'b1);

    // Trap beats branch and JALR; in FLUSH branch ignored, trap restarts.
    cyc("trall", 0, 1, 32'd9, 1, 32'h0000_0200, 1, 32'd5, 1);
    cyc("flbr", 0, 1, 32'd3, 0, '0, 0, '0, 1);
    idle("run", 1'b1);
    cyc("trjm", 0, 0, '0, 1, 32'h0000_0003, 1, 32'd77, 1);
    cyc("fltr", 0, 0, '0, 0, '0, 1, 32'd78, 1);
    cyc("flmis", 0, 0, '0, 1, 32'h0000_0011, 0, 32'd79, 1);
    idle("fl", 1'b1);

    // PC wrap at 2^32.
    cyc("brmax", 0, 1, 32'hFFFF_FFFF, 0, '0, 0, '0, 1);
    idle("flmax", 1'b1);
    idle("wrap", 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      cyc("rnd", ($urandom_range(3) == 0), ($urandom_range(5) == 0), $urandom,
          ($urandom_range(7) == 0), {$urandom_range(255), 2'b00} | {30'd0, r[1:0] & {2{r[2]}}},
          ($urandom_range(15) == 0), $urandom, ($urandom_range(3) != 0));
    end

    // Asynchronous reset mid-cycle while flush is high.
    cyc("brpre", 0, 1, 32'd50, 0, '0, 0, '0, 1);
    chk("pre.flush", {31'd0, flush}, 32'd1);
    #2;
    do_reset();
    idle("boot2", 1'b1);
    idle("seq2", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
